// File: rtl/regfile.sv
// General-purpose register file: one write port from write-back, two operand
// read ports and one debug read port, all combinational with write-through bypass.
module regfile #(
  parameter int                 NUM_REGS  = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = $clog2(NUM_REGS),
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // NOTE: every entry carries a reset value, so this array is built from
  // flops and cannot be mapped onto a RAM macro; that is intended here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: state is updated with <= so all readers in this edge see the old value.
        regs[i] <= RESET_VAL;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read priority: reset, disabled port, r0, same-cycle write bypass, array.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              rst_i,
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    if (rst_i || !en || (addr == '0)) begin
      return '0;
    end else if (wr_en && (wr_addr == addr)) begin
      return wr_data;
    end else begin
      return stored;
    end
  endfunction

  assign rdata1    = read_mux(rst, re1,  raddr1,    we, waddr, wdata, regs[raddr1]);
  assign rdata2    = read_mux(rst, re2,  raddr2,    we, waddr, wdata, regs[raddr2]);
  assign dbg_rdata = read_mux(rst, 1'b1, dbg_raddr, we, waddr, wdata, regs[dbg_raddr]);

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: the stimulus process queues hand-computed
// expectations per cycle, and a negedge monitor pops and compares all three read ports.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  typedef struct {
    int          step;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  regfile dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int s,
                       input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, s, act, exp_v);
    end
  endtask

  // Monitor: the outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("rdata1",    e.step, rdata1,    e.e1);
      check("rdata2",    e.step, rdata2,    e.e2);
      check("dbg_rdata", e.step, dbg_rdata, e.ed);
    end
  end

  function automatic logic [31:0] sweep_val(input int i);
    logic [31:0] v;
    v = i;
    return (i == 0) ? 32'h0 : ((v << 24) | v);
  endfunction

  // Drive one cycle of inputs just after posedge and queue its expected outputs.
  task automatic cyc(input logic r, input logic w, input logic [4:0] wa,
                     input logic [31:0] wd, input logic e1_en, input logic [4:0] a1,
                     input logic e2_en, input logic [4:0] a2, input logic [4:0] ad,
                     input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] xd);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1_en; raddr1 = a1; re2 = e2_en; raddr2 = a2; dbg_raddr = ad;
    step++;
    e.step = step; e.e1 = x1; e.e2 = x2; e.ed = xd;
    sb_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0; dbg_raddr = '0;

    // Reset held two cycles with a write pending: everything reads zero.
    cyc(1, 1, 5, 32'hDEAD_BEEF, 1, 5, 1, 5, 5, 0, 0, 0);
    cyc(1, 1, 5, 32'hDEAD_BEEF, 1, 5, 1, 5, 5, 0, 0, 0);
    cyc(0, 0, 5, 32'h0,         1, 5, 1, 5, 5, 0, 0, 0);

    // Write r7; debug port sees the bypass, disabled ports read zero.
    cyc(0, 1, 7, 32'h1234_5678, 0, 7, 0, 7, 7, 0, 0, 32'h1234_5678);
    cyc(0, 0, 0, 32'h0,         1, 7, 1, 7, 7, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    cyc(0, 0, 0, 32'h0,         0, 7, 1, 7, 7, 0, 32'h1234_5678, 32'h1234_5678);

    // Bypass on all three ports, then value held in the array.
    cyc(0, 1, 9, 32'hA5A5_0001, 1, 9, 1, 9, 9, 32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001);
    cyc(0, 0, 9, 32'h0,         1, 9, 1, 9, 9, 32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_0001);

    // r0 ignores writes and never bypasses.
    cyc(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 32'h0,         1, 0, 1, 0, 0, 0, 0, 0);

    // Reset mid-stream drops the concurrent write and clears earlier ones.
    cyc(0, 1, 3, 32'h11, 1, 3, 1, 9, 3, 32'h11, 32'hA5A5_0001, 32'h11);
    cyc(1, 1, 3, 32'h22, 1, 3, 1, 3, 3, 0, 0, 0);
    cyc(0, 0, 3, 32'h0,  1, 3, 1, 9, 7, 0, 0, 0);

    // Sweep: write r1..r31 (bypass visible on port 1 and debug), then read back.
    for (int i = 1; i < 32; i++) begin
      cyc(0, 1, 5'(i), sweep_val(i), 1, 5'(i), 0, 5'(i), 5'(i),
          sweep_val(i), 0, sweep_val(i));
    end
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 32'h0, 1, 5'(i), 1, 5'(31 - i), 5'(i),
          sweep_val(i), sweep_val(31 - i), sweep_val(i));
    end

    // Both operand ports bypass together while debug reads a stored register.
    cyc(0, 1, 4, 32'hCAFE_F00D, 1, 4, 1, 4, 5, 32'hCAFE_F00D, 32'hCAFE_F00D, sweep_val(5));
    cyc(0, 0, 0, 32'h0,         1, 4, 0, 4, 4, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);

    // Give the monitor a bounded number of cycles to drain the scoreboard.
    for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t want=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
